// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte stream and status bundle between uart_rx, the rx FIFO and its consumer
interface uart_rx_fifo_if #(
  parameter int N_DATA  = 8,
  parameter int NB_ADDR = 4
);
  logic [N_DATA-1:0]  i_rx_data;
  logic               i_rx_done;
  logic               i_rd;
  logic               i_clr_ovf;
  logic [N_DATA-1:0]  o_data;
  logic               o_valid;
  logic [NB_ADDR:0]   o_count;
  logic               o_full;
  logic               o_empty;
  logic               o_overflow;

  // Producer/consumer side: drives strobes, observes head byte and status
  modport master (
    output i_rx_data, i_rx_done, i_rd, i_clr_ovf,
    input  o_data, o_valid, o_count, o_full, o_empty, o_overflow
  );

  // FIFO side
  modport slave (
    input  i_rx_data, i_rx_done, i_rd, i_clr_ovf,
    output o_data, o_valid, o_count, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO with sticky overflow flag
module uart_rx_fifo #(
  parameter int N_DATA  = 8,
  parameter int NB_ADDR = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);
  localparam logic [NB_ADDR:0]   CNT_FULL = (NB_ADDR + 1)'(DEPTH);
  localparam logic [NB_ADDR-1:0] PTR_ONE  = NB_ADDR'(1);

  logic [N_DATA-1:0]  mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               overflow;

  logic full;
  logic valid;
  logic rd_en;
  logic wr_en;
  logic drop;

  // Status flags come from the registered count only; a pop frees the slot a
  // same-cycle write uses, so a full FIFO still accepts a write when popped.
  always_comb begin
    full  = (count == CNT_FULL);
    valid = (count != '0);
    rd_en = bus.i_rd && valid;
    wr_en = bus.i_rx_done && (!full || rd_en);
    drop  = bus.i_rx_done && full && !rd_en;
  end

  // Pointers, count, overflow flag and storage; the array is never reset,
  // and being inside the reset branch's else keeps writes off during reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= bus.i_rx_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A new drop wins over a clear in the same cycle
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.i_clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Show-ahead head byte, forced to zero while empty so stale storage never leaks
  always_comb begin
    bus.o_data     = valid ? mem[rd_ptr] : '0;
    bus.o_valid    = valid;
    bus.o_count    = count;
    bus.o_full     = full;
    bus.o_empty    = !valid;
    bus.o_overflow = overflow;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter N_DATA, default 8: byte width, matching the uart_rx o_data width.
REQ-002 Parameter NB_ADDR, default 4: log2 of the FIFO depth, so DEPTH = 2**NB_ADDR = 16.
REQ-003 Port i_clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_rx_data, input, N_DATA: received byte from uart_rx.
REQ-006 Port i_rx_done, input, 1: one-cycle write strobe from uart_rx, sampled together with i_rx_data.
REQ-007 Port i_rd, input, 1: pop request from uart_alu_interface.
REQ-008 Port o_data, output, N_DATA: head byte (show-ahead).
REQ-009 Port o_valid, output, 1: o_data holds a valid head byte (FIFO not empty).
REQ-010 Port o_count, output, NB_ADDR+1: number of stored bytes, 0..DEPTH.
REQ-011 Port o_full, output, 1: o_count == DEPTH.
REQ-012 Port o_empty, output, 1: o_count == 0.
REQ-013 Port o_overflow, output, 1: sticky flag meaning a byte was dropped.
REQ-014 Port i_clr_ovf, input, 1: synchronous clear for o_overflow.

Function
REQ-015 Storage SHALL be a DEPTH x N_DATA register array with NB_ADDR-bit write and read pointers that wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-016 Write: i_rx_done=1 and o_full=0 SHALL store i_rx_data at the write pointer, then increment the write pointer.
REQ-017 Pop: i_rd=1 and o_valid=1 SHALL increment the read pointer.
REQ-018 i_rd=1 while o_empty=1 SHALL be ignored: no pointer or count change and no error flag.
REQ-019 o_data SHALL equal the byte at the read pointer whenever o_valid=1, and SHALL be 0 whenever o_empty=1.
REQ-020 Write-to-read latency: a byte written at edge k SHALL be visible on o_data with o_valid=1 immediately after edge k, not earlier.
REQ-021 o_count update: +1 on write only; -1 on pop only; unchanged on simultaneous write and pop; unchanged otherwise.
REQ-022 o_valid, o_full and o_empty SHALL be derived from registered state only, with no combinational path from i_rd or i_rx_done.
REQ-023 Full plus write without pop: the byte SHALL be dropped, contents and pointers unchanged, and o_overflow set to 1 on that edge.
REQ-024 Full plus simultaneous write and pop: both SHALL occur, o_count stays DEPTH, and o_overflow is unchanged.
REQ-025 Empty plus simultaneous write and pop: the pop SHALL be ignored and the write occurs, giving o_count=1 and o_valid=1 next cycle.
REQ-026 o_overflow SHALL hold 1 until a cycle with i_clr_ovf=1.
REQ-027 If i_clr_ovf=1 in the same cycle as a new drop, o_overflow SHALL remain 1 (set wins).
REQ-028 i_clr_ovf SHALL affect no other state.
REQ-029 Pointers SHALL NOT advance on any other condition.

Reset
REQ-030 i_rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- write and read pointers = 0;
- o_count = 0, o_empty = 1, o_full = 0, o_valid = 0, o_data = 0, o_overflow = 0.
REQ-031 The storage array SHALL NOT be reset; its contents are unobservable while o_empty=1.
REQ-032 Reset asserted mid-operation (FIFO partly filled, or a write strobe in the same cycle) SHALL discard all contents, and no write SHALL occur while i_rst_n=0.
REQ-033 After i_rst_n rises, the first rising edge SHALL already accept i_rx_done.

Verification
REQ-034 Basic ordering: write 0x11, 0x22, 0x33 on separate strobes -> o_count=3, then pops return 0x11, 0x22, 0x33 in order, ending with o_empty=1 and o_data=0.
REQ-035 Fill and overflow: write 0x00..0x0F -> o_full=1, o_count=16. A 17th write of 0xAA -> o_overflow=1, count stays 16, and 16 pops return 0x00..0x0F (0xAA absent).
REQ-036 Full with simultaneous write and pop: with FIFO full of 0x00..0x0F, write 0x55 while popping -> o_count=16, o_overflow=0, o_data=0x01 next cycle, and 0x55 is the last byte popped.
REQ-037 Wrap-around and underflow:
- 40 interleaved write/pop pairs with values 0..39 -> every popped byte matches;
- pointers wrap at least twice;
- i_rd pulses while empty leave o_count=0.
REQ-038 Reset and overflow clear:
- 5 bytes stored, o_overflow=1; drop i_rst_n asynchronously between edges -> all outputs reach reset values before the next edge;
- separately, i_clr_ovf coincident with a new drop -> o_overflow stays 1.
